// File: rtl/div_meter_pkg.sv
// rtl/div_meter_pkg.sv - shared types and digit helpers for the divergence meter
package div_meter_pkg;

  typedef enum logic [1:0] {IDLE, ROLL, SETTLE} state_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
    return (nibble > 4'd9) ? 4'd9 : nibble;
  endfunction

  // Folds 10..15 onto 0..5 so any LFSR nibble becomes a displayable digit.
  function automatic logic [3:0] nib_to_digit(input logic [3:0] nibble);
    return (nibble >= 4'd10) ? nibble - 4'd10 : nibble;
  endfunction

endpackage

// File: rtl/div_lfsr32.sv
// rtl/div_lfsr32.sv - free-running 32-bit Galois LFSR
module div_lfsr32
  import div_meter_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2024
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] state
);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= SEED;
    end else begin
      state <= (state >> 1) ^ (state[0] ? LFSR_POLY : 32'd0);
    end
  end

endmodule

// File: rtl/divergence_roller.sv
// rtl/divergence_roller.sv - rolling-digit animation feeding the 8-digit scanner
module divergence_roller
  import div_meter_pkg::*;
#(
  parameter int          TICK_DIV     = 50000,
  parameter int          ROLL_TICKS   = 64,
  parameter int          SETTLE_TICKS = 8,
  parameter logic [31:0] SEED         = 32'hACE1_2024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] Target,
  output logic [31:0] Disp_Data,
  output logic        Disp_En,
  output logic        Busy,
  output logic        Done
);

  state_t      state;
  logic [31:0] lfsr;
  logic [31:0] target_q;
  logic [31:0] target_clamped;
  logic [31:0] rand_word;
  logic [31:0] settle_word;
  logic [31:0] tick_cnt;
  logic [31:0] roll_cnt;
  logic [31:0] settle_cnt;
  logic [3:0]  lock_cnt;
  logic [3:0]  lock_next;
  logic        tick;

  div_lfsr32 #(.SEED(SEED)) u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .state (lfsr)
  );

  // lock_next is the lock count this settle update will display, so a new
  // digit locks on the same strobe that bumps the count.
  always_comb begin
    tick           = (state != IDLE) && (tick_cnt == TICK_DIV - 1);
    lock_next      = (settle_cnt == SETTLE_TICKS - 1) ? lock_cnt + 4'd1 : lock_cnt;
    rand_word      = '0;
    settle_word    = '0;
    target_clamped = '0;
    for (int i = 0; i < 8; i++) begin
      rand_word[4*i +: 4]      = nib_to_digit(lfsr[4*i +: 4]);
      target_clamped[4*i +: 4] = bcd_clamp(Target[4*i +: 4]);
      settle_word[4*i +: 4]    = ((32'(i) + 32'(lock_next)) >= 32'd8) ?
                                 target_q[4*i +: 4] : rand_word[4*i +: 4];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      target_q   <= '0;
      tick_cnt   <= '0;
      roll_cnt   <= '0;
      settle_cnt <= '0;
      lock_cnt   <= '0;
      Disp_Data  <= '0;
      Disp_En    <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      Disp_En  <= 1'b0;
      Done     <= 1'b0;
      tick_cnt <= (tick_cnt == TICK_DIV - 1) ? 32'd0 : tick_cnt + 32'd1;
      case (state)
        IDLE: begin
          if (Start) begin
            target_q   <= target_clamped;
            tick_cnt   <= '0;
            roll_cnt   <= '0;
            settle_cnt <= '0;
            lock_cnt   <= '0;
            Busy       <= 1'b1;
            state      <= ROLL;
          end
        end
        ROLL: begin
          if (tick) begin
            Disp_Data <= rand_word;
            Disp_En   <= 1'b1;
            if (roll_cnt == ROLL_TICKS - 1) begin
              settle_cnt <= '0;
              lock_cnt   <= '0;
              state      <= SETTLE;
            end else begin
              roll_cnt <= roll_cnt + 32'd1;
            end
          end
        end
        SETTLE: begin
          if (tick) begin
            Disp_En    <= 1'b1;
            lock_cnt   <= lock_next;
            settle_cnt <= (settle_cnt == SETTLE_TICKS - 1) ? 32'd0 : settle_cnt + 32'd1;
            if (lock_next == 4'd8) begin
              Disp_Data <= target_q;
              Done      <= 1'b1;
              Busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              Disp_Data <= settle_word;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divergence_roller.sv
// tb/tb_divergence_roller.sv - directed self-checking bench for divergence_roller
module tb_divergence_roller;

  localparam int TICK_DIV     = 4;
  localparam int ROLL_TICKS   = 3;
  localparam int SETTLE_TICKS = 2;
  localparam int STROBES      = ROLL_TICKS + 8 * SETTLE_TICKS;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [31:0] Target = '0;
  logic [31:0] Disp_Data;
  logic        Disp_En;
  logic        Busy;
  logic        Done;

  int passed = 0;
  int total  = 0;

  logic [31:0] sd[$];
  int          sk[$];
  bit          sdone[$];
  int          done_cnt;

  divergence_roller #(
    .TICK_DIV     (TICK_DIV),
    .ROLL_TICKS   (ROLL_TICKS),
    .SETTLE_TICKS (SETTLE_TICKS),
    .SEED         (32'hACE1_2024)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Target    (Target),
    .Disp_Data (Disp_Data),
    .Disp_En   (Disp_En),
    .Busy      (Busy),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic bit digits_ok(input logic [31:0] w);
    for (int i = 0; i < 8; i++) begin
      if (w[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Pulses Start for one cycle; the returned step lands just after the sampling edge.
  task automatic start_run(input logic [31:0] tgt);
    Start  = 1'b1;
    Target = tgt;
    step();
    Start = 1'b0;
  endtask

  // Records strobes until Done, until abort_at strobes, or until the cycle budget runs out.
  task automatic watch(input int budget, input int abort_at, input int poke_k);
    sd.delete();
    sk.delete();
    sdone.delete();
    done_cnt = 0;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (poke_k != 0 && k == poke_k) begin
        Start  = 1'b1;
        Target = 32'h0;
      end
      if (poke_k != 0 && k == poke_k + 1) Start = 1'b0;
      if (Done) done_cnt++;
      if (Disp_En) begin
        sd.push_back(Disp_Data);
        sk.push_back(k);
        sdone.push_back(Done);
      end
      if (Done) break;
      if (abort_at != 0 && sd.size() == abort_at) break;
    end
    Start = 1'b0;
  endtask

  // Strobe-level checks shared by every complete run.
  task automatic check_run(input string tag, input logic [31:0] final_exp);
    int bad_space, bad_digit, bad_lock, lock;
    logic [31:0] last;
    bad_space = 0;
    bad_digit = 0;
    bad_lock  = 0;
    last      = (sd.size() > 0) ? sd[sd.size()-1] : 32'hxxxx_xxxx;
    chk({tag, "_strobes"}, sd.size(), STROBES);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_final"}, last, final_exp);
    for (int j = 0; j < sd.size(); j++) begin
      if (j > 0 && sk[j] - sk[j-1] != TICK_DIV) bad_space++;
      if (!digits_ok(sd[j])) bad_digit++;
      lock = (j >= ROLL_TICKS) ? (j - ROLL_TICKS + 1) / SETTLE_TICKS : 0;
      for (int n = 8 - lock; n < 8; n++) begin
        if (sd[j][4*n +: 4] !== final_exp[4*n +: 4]) bad_lock++;
      end
    end
    chk({tag, "_spacing"}, bad_space, 0);
    chk({tag, "_digits"}, bad_digit, 0);
    chk({tag, "_locks"}, bad_lock, 0);
  endtask

  initial begin
    step();
    step();
    chk("rst_data", Disp_Data, 32'h0);
    chk("rst_en", Disp_En, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    Reset = 1'b0;
    step();
    step();

    // Nominal run with lock-order spot checks.
    start_run(32'h1048_5960);
    chk("nom_busy_rise", Busy, 1'b1);
    watch(200, 0, 0);
    chk("nom_first_k", (sk.size() > 0) ? sk[0] : -1, TICK_DIV);
    chk("nom_last_done", (sdone.size() > 0) ? sdone[sdone.size()-1] : 1'b0, 1'b1);
    chk("nom_lock_s2", (sd.size() > 4) ? {28'd0, sd[4][31:28]} : 32'hx, 32'h1);
    chk("nom_lock_s4", (sd.size() > 6) ? {24'd0, sd[6][31:24]} : 32'hx, 32'h10);
    chk("nom_lock_s6", (sd.size() > 8) ? {20'd0, sd[8][31:20]} : 32'hx, 32'h104);
    check_run("nom", 32'h1048_5960);
    step();
    chk("nom_busy_fall", Busy, 1'b0);
    chk("nom_done_pulse", Done, 1'b0);
    chk("nom_hold", Disp_Data, 32'h1048_5960);
    step();

    // Nibbles above 9 clamp to 9.
    start_run(32'hFFFF_ABCD);
    watch(200, 0, 0);
    check_run("clamp", 32'h9999_9999);
    step();

    // Start and Target changes during ROLL are ignored.
    start_run(32'h1234_5678);
    watch(200, 0, 6);
    check_run("ign", 32'h1234_5678);

    // Start in the cycle right after Done is accepted.
    start_run(32'h8765_4321);
    chk("b2b_busy", Busy, 1'b1);
    watch(200, 0, 0);
    check_run("b2b", 32'h8765_4321);
    step();

    // Reset mid-run aborts without Done.
    start_run(32'h2222_3333);
    watch(200, 10, 0);
    chk("abort_strobes", sd.size(), 10);
    chk("abort_no_done", done_cnt, 0);
    #2;
    Reset = 1'b1;
    #1;
    chk("abort_data", Disp_Data, 32'h0);
    chk("abort_en", Disp_En, 1'b0);
    chk("abort_busy", Busy, 1'b0);
    chk("abort_done", Done, 1'b0);
    step();
    Reset = 1'b0;
    step();
    start_run(32'h0909_0909);
    watch(200, 0, 0);
    check_run("post_abort", 32'h0909_0909);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
